// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO sizing defaults and skid-buffer state encoding.
package fifo_pkg;

    localparam int ADDRESS_WIDTH = 3;
    localparam int ADDRESS_DEPTH = 2 ** ADDRESS_WIDTH;
    localparam int PTR_W         = ADDRESS_WIDTH + 1;

    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_TWO   = 2'd2
    } cnt_e;

endpackage

// File: rtl/gray2bin.sv
// gray2bin: combinational gray-to-binary converter, bit i = XOR of gray bits i..MSB.
module gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end

endmodule

// File: rtl/fifo_wr_frontend.sv
// fifo_wr_frontend: 2-entry skid buffer feeding the async FIFO write side,
// plus registered level, almost-full and sticky pointer-sanity error.
module fifo_wr_frontend #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = fifo_pkg::ADDRESS_WIDTH,
    parameter int ADDRESS_DEPTH = fifo_pkg::ADDRESS_DEPTH,
    parameter int AFULL_THRESH  = 6
) (
    input  logic                     wclk,
    input  logic                     wrst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_WIDTH-1:0]    s_data,
    input  logic                     wfull,
    input  logic [ADDRESS_WIDTH:0]   wptr,
    input  logic [ADDRESS_WIDTH:0]   wq2_rptr,
    input  logic                     clr_err,
    output logic                     winc,
    output logic [DATA_WIDTH-1:0]    wdata,
    output logic [ADDRESS_WIDTH:0]   wlevel,
    output logic                     walmost_full,
    output logic                     wptr_err
);

    import fifo_pkg::*;

    localparam int PW = ADDRESS_WIDTH + 1;
    localparam logic [PW-1:0] AFULL_L = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] DEPTH_L = PW'(ADDRESS_DEPTH);

    cnt_e                  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW-1:0]         wlevel_q, wlevel_d;
    logic                  afull_q, afull_d, err_q, err_d;
    logic [PW-1:0]         wbin, rbin, diff;
    logic                  accept, drain;

    gray2bin #(.W(PW)) u_wptr_bin  (.gray(wptr),     .bin(wbin));
    gray2bin #(.W(PW)) u_rptr_bin  (.gray(wq2_rptr), .bin(rbin));

    // s_ready depends only on the registered count, never on s_valid
    assign s_ready = (cnt_q != CNT_TWO);
    assign winc    = (cnt_q != CNT_EMPTY) & ~wfull;
    assign wdata   = (cnt_q == CNT_EMPTY) ? '0 : head_q;
    assign accept  = s_valid & s_ready;
    assign drain   = winc;
    assign diff    = wbin - rbin;

    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        case (cnt_q)
            CNT_EMPTY: if (accept) begin
                head_d = s_data;
                cnt_d  = CNT_ONE;
            end
            CNT_ONE: begin
                if (accept && drain) head_d = s_data;
                else if (accept) begin
                    tail_d = s_data;
                    cnt_d  = CNT_TWO;
                end else if (drain) cnt_d = CNT_EMPTY;
            end
            CNT_TWO: if (drain) begin
                head_d = tail_q;
                cnt_d  = CNT_ONE;
            end
            default: cnt_d = CNT_EMPTY;
        endcase
        wlevel_d = diff;
        afull_d  = diff >= AFULL_L;
        err_d    = (diff > DEPTH_L) ? 1'b1 : clr_err ? 1'b0 : err_q;
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            cnt_q    <= CNT_EMPTY;
            head_q   <= '0;
            tail_q   <= '0;
            wlevel_q <= '0;
            afull_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            wlevel_q <= wlevel_d;
            afull_q  <= afull_d;
            err_q    <= err_d;
        end
    end

    assign wlevel       = wlevel_q;
    assign walmost_full = afull_q;
    assign wptr_err     = err_q;

endmodule

// File: tb/tb_fifo_wr_frontend.sv
// tb_fifo_wr_frontend: directed stimulus with a write scoreboard checked by a separate monitor.
module tb_fifo_wr_frontend;

    logic       wclk = 1'b0;
    logic       wrst_n;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       wfull;
    logic [3:0] wptr;
    logic [3:0] wq2_rptr;
    logic       clr_err;
    logic       winc;
    logic [7:0] wdata;
    logic [3:0] wlevel;
    logic       walmost_full;
    logic       wptr_err;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    fifo_wr_frontend dut (
        .wclk(wclk), .wrst_n(wrst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .wfull(wfull), .wptr(wptr), .wq2_rptr(wq2_rptr),
        .clr_err(clr_err), .winc(winc), .wdata(wdata), .wlevel(wlevel),
        .walmost_full(walmost_full), .wptr_err(wptr_err)
    );

    always #5 wclk = ~wclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic check_reset_vals();
        check("rst_s_ready", s_ready, 1);
        check("rst_winc", winc, 0);
        check("rst_wdata", wdata, 0);
        check("rst_wlevel", wlevel, 0);
        check("rst_afull", walmost_full, 0);
        check("rst_err", wptr_err, 0);
    endtask

    // monitor: every FIFO write must pop the oldest expected word
    always @(negedge wclk) begin
        if (wrst_n) begin
            check("winc_while_full", winc & wfull, 0);
            if (winc) begin
                if (exp_q.size() == 0) check("unexpected_write", wdata, 32'hFFFF_FFFF);
                else check("wdata_order", wdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        wrst_n = 0; s_valid = 0; s_data = 0; wfull = 0;
        wptr = 0; wq2_rptr = 0; clr_err = 0;
        #12;
        check_reset_vals();
        step(); wrst_n = 1;
        @(negedge wclk);
        check_reset_vals();

        // single word: one cycle of latency, one write
        step(); s_valid = 1; s_data = 8'hA5; exp_q.push_back(8'hA5);
        @(negedge wclk); check("single_ready", s_ready, 1); check("single_lat", winc, 0);
        step(); s_valid = 0;
        @(negedge wclk); check("single_winc", winc, 1); check("single_wdata", wdata, 8'hA5);
        step();
        @(negedge wclk); check("single_done", winc, 0); check("single_wdata0", wdata, 0);

        // backpressure
        step(); wfull = 1; s_valid = 1; s_data = 8'h11; exp_q.push_back(8'h11);
        @(negedge wclk); check("bp_ready0", s_ready, 1);
        step(); s_data = 8'h22; exp_q.push_back(8'h22);
        @(negedge wclk); check("bp_ready1", s_ready, 1); check("bp_winc1", winc, 0);
        step(); s_data = 8'h33; exp_q.push_back(8'h33);
        @(negedge wclk); check("bp_ready2", s_ready, 0); check("bp_winc2", winc, 0);
        step();
        @(negedge wclk); check("bp_ready3", s_ready, 0); check("bp_winc3", winc, 0);
        step(); wfull = 0;
        @(negedge wclk); check("bp_rel_winc", winc, 1); check("bp_rel_wdata", wdata, 8'h11);
        check("bp_rel_ready", s_ready, 0);
        step();
        @(negedge wclk); check("bp_w2", winc, 1); check("bp_w2_data", wdata, 8'h22);
        check("bp_ready_back", s_ready, 1);
        step(); s_valid = 0;
        @(negedge wclk); check("bp_w3", winc, 1); check("bp_w3_data", wdata, 8'h33);
        step();
        @(negedge wclk); check("bp_idle", winc, 0);

        // streaming 20 words
        for (int i = 0; i < 20; i++) begin
            step(); s_valid = 1; s_data = 8'(i); exp_q.push_back(8'(i));
            @(negedge wclk);
            check("stream_ready", s_ready, 1);
            if (i > 0) check("stream_winc", winc, 1);
        end
        step(); s_valid = 0;
        @(negedge wclk); check("stream_last", wdata, 8'h13); check("stream_last_winc", winc, 1);
        step();
        @(negedge wclk); check("stream_idle", winc, 0); check("stream_q_empty", exp_q.size(), 0);

        // level and wrap
        step(); wptr = 4'b1101; wq2_rptr = 4'b0010;
        @(negedge wclk); check("lvl_latency", wlevel, 0);
        step();
        @(negedge wclk); check("lvl6", wlevel, 6); check("afull6", walmost_full, 1);
        step(); wptr = 4'b0111; wq2_rptr = 4'b0000;
        step();
        @(negedge wclk); check("lvl5", wlevel, 5); check("afull5", walmost_full, 0);
        step(); wptr = 4'b0001; wq2_rptr = 4'b1011;
        step();
        @(negedge wclk); check("lvl_wrap", wlevel, 4); check("afull_wrap", walmost_full, 0);
        step(); wptr = 4'b1100; wq2_rptr = 4'b0000;
        step();
        @(negedge wclk); check("lvl8", wlevel, 8); check("err_at8", wptr_err, 0);
        check("afull8", walmost_full, 1);

        // error: set, sticky, clear, set-over-clear
        step(); wptr = 4'b1111; wq2_rptr = 4'b0000;
        step();
        @(negedge wclk); check("err_set", wptr_err, 1); check("lvl10", wlevel, 10);
        step(); wptr = 4'b0000;
        step();
        @(negedge wclk); check("err_sticky", wptr_err, 1); check("lvl0", wlevel, 0);
        step(); clr_err = 1;
        step(); clr_err = 0;
        @(negedge wclk); check("err_clr", wptr_err, 0);
        step(); wptr = 4'b1111; clr_err = 1;
        step(); wptr = 4'b0000;
        @(negedge wclk); check("err_set_prio", wptr_err, 1);
        step(); clr_err = 0;
        @(negedge wclk); check("err_clr2", wptr_err, 0);

        // reset mid-stream drops buffered words
        step(); wfull = 1; wptr = 4'b1111; s_valid = 1; s_data = 8'h44;
        step(); s_data = 8'h55;
        step(); s_valid = 0;
        @(negedge wclk); check("pre_rst_ready", s_ready, 0); check("pre_rst_err", wptr_err, 1);
        step(); wfull = 0; wrst_n = 0;
        #1;
        check_reset_vals();
        exp_q.delete();
        wptr = 0;
        step(); wrst_n = 1;
        @(negedge wclk); check("post_rst_winc", winc, 0);
        step(); s_valid = 1; s_data = 8'h77; exp_q.push_back(8'h77);
        step(); s_valid = 0;
        @(negedge wclk); check("post_rst_write", wdata, 8'h77);
        step();
        step();
        check("final_q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_frontend.md
Name: fifo_wr_frontend

Overview:
Write-domain front end that sits directly upstream of the async FIFO write-pointer block. It accepts a valid/ready data stream and holds data in a 2-entry skid buffer. It drives winc/wdata into the FIFO write pointer and memory, and never asserts winc while wfull is high. It also reports registered fill level, almost-full, and a sticky pointer-sanity error, all derived from the gray-coded write pointer and the synchronized read pointer.

Parameters:
DATA_WIDTH, 8, width of stream and FIFO data word
ADDRESS_WIDTH, 3, FIFO address bits; pointers are ADDRESS_WIDTH+1 bits
ADDRESS_DEPTH, 8, FIFO depth, equals 2**ADDRESS_WIDTH
AFULL_THRESH, 6, level at or above which walmost_full asserts

Ports:
wclk  in  1  write clock
wrst_n  in  1  asynchronous active-low reset
s_valid  in  1  upstream data valid
s_ready  out  1  frontend can accept a word this cycle
s_data  in  DATA_WIDTH  upstream data
wfull  in  1  FIFO full, from write-pointer block
wptr  in  ADDRESS_WIDTH+1  gray write pointer, registered in write-pointer block
wq2_rptr  in  ADDRESS_WIDTH+1  gray read pointer, double-flop synchronized into wclk
clr_err  in  1  clears wptr_err
winc  out  1  write strobe to FIFO
wdata  out  DATA_WIDTH  write data to FIFO memory, valid whenever winc=1
wlevel  out  ADDRESS_WIDTH+1  registered FIFO occupancy estimate
walmost_full  out  1  registered, wlevel >= AFULL_THRESH
wptr_err  out  1  sticky, pointer difference exceeds ADDRESS_DEPTH

Behaviour:
- Reset (async, wrst_n=0) values:
  - cnt=0; both buffer entries cleared to 0.
  - s_ready=1, winc=0, wdata=0.
  - wlevel=0, walmost_full=0, wptr_err=0.
  - Reset mid-transfer drops all buffered words.
- Skid buffer: 2 entries, FIFO order, head = older word.
  - State cnt is one of EMPTY(0), ONE(1), TWO(2).
  - accept = s_valid & s_ready.
  - drain = winc.
- Output logic:
  - winc = (cnt != 0) & ~wfull; combinational from the cnt register and wfull.
  - wdata = head entry; zero when cnt=0.
  - The FIFO writes wdata and advances its pointer on the same wclk edge as winc.
- s_ready = (cnt != 2), decoded from the cnt register only, with no combinational path from s_valid. Upstream handshake rule: a word transfers on a rising edge where s_valid=1 and s_ready=1.
- cnt transitions:
  - EMPTY: accept -> ONE. The word is not written in the same cycle; winc rises the next cycle, giving 1-cycle minimum latency.
  - ONE: accept & drain -> ONE (new word becomes head). accept only -> TWO. drain only -> EMPTY.
  - TWO: drain -> ONE (tail shifts to head). Otherwise hold. No accept is possible in TWO.
- wfull high: drain is suppressed, the buffer fills to TWO, then s_ready=0. When wfull falls, the head is written on the first cycle after, with no data loss or duplication.
- Level:
  - Gray-to-binary convert wptr and wq2_rptr.
  - diff = bin(wptr) - bin(wq2_rptr), modulo 2**(ADDRESS_WIDTH+1), so wrap is handled naturally.
  - wlevel <= diff, registered with 1-cycle latency.
  - wlevel is pessimistic: read progress is seen 2+ cycles late.
- walmost_full <= (diff >= AFULL_THRESH), same cycle as wlevel.
- wptr_err:
  - Set on a clock edge where diff > ADDRESS_DEPTH.
  - Cleared by clr_err. Set has priority over clear when both occur in the same cycle.
  - Holds otherwise.
- No internal state depends on wptr/wq2_rptr except wlevel, walmost_full and wptr_err.

Decomposition:
- Shared package fifo_pkg:
  - ADDRESS_WIDTH/ADDRESS_DEPTH defaults.
  - Pointer width constant PTR_W = ADDRESS_WIDTH+1.
  - Buffer state encoding constants CNT_EMPTY/CNT_ONE/CNT_TWO.
- One sub-module, gray2bin, parameterized by width and purely combinational: bit i = XOR of gray bits i..MSB.
  - Instantiate twice, for wptr and wq2_rptr.
  - Reusable by the read-side counterpart.

Test Plan:
- Reset then idle, wfull=0, pointers 0:
  - Expected: s_ready=1, winc=0, wlevel=0, walmost_full=0, wptr_err=0.
- Single word:
  - Stimulus: s_data=0xA5 with s_valid for 1 cycle.
  - Expected next cycle: winc=1, wdata=0xA5 for exactly 1 cycle, then cnt=0.
- Backpressure:
  - Stimulus: hold wfull=1 and offer 0x11, 0x22, 0x33 back-to-back.
  - Expected: 0x11/0x22 accepted; s_ready=0 from the cycle after the second accept; 0x33 held by upstream; winc stays 0.
  - Then drop wfull. Expected: winc writes 0x11, 0x22, 0x33 in order, no gaps after the first, no duplicates.
- Streaming:
  - Stimulus: s_valid continuously high, wfull=0, 20 words 0x00..0x13.
  - Expected: s_ready stays 1; winc=1 every cycle from the 2nd onward; output order matches input.
- Level and wrap:
  - Stimulus: wptr=gray(9)=4'b1101, wq2_rptr=gray(3)=4'b0010.
  - Expected next cycle: wlevel=6, walmost_full=1.
  - Stimulus: wptr=gray(1)=4'b0001, wq2_rptr=gray(13)=4'b1011.
  - Expected: wlevel=4, walmost_full=0.
- Error:
  - Stimulus: wptr=gray(10)=4'b1111, wq2_rptr=gray(0).
  - Expected: diff=10 > 8, so wptr_err=1 and it stays set after the pointers become equal.
  - Stimulus: clr_err=1 for 1 cycle. Expected: wptr_err=0.
  - Stimulus: reset asserted mid-stream. Expected: all outputs return to reset values immediately.
